// File: rtl/operand_fetch_stage.sv
// Operand fetch: reads the register file, forwards EX/MEM results, stalls on
// load-use hazards and registers resolved operands into the ID/EX register.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high; valid never depends on ready, and ready may depend on valid.
module operand_fetch_stage #(
   parameter int PROC_DATA_WIDTH        = 16,
   parameter int PROC_REGFILE_LOG2_DEEP = 5,
   parameter int IMM_WIDTH              = 8,
   parameter int OP_WIDTH               = 4
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              flush_i,
   input  logic                              in_valid_i,
   output logic                              in_ready_o,
   input  logic [OP_WIDTH-1:0]               op_i,
   input  logic [PROC_REGFILE_LOG2_DEEP-1:0] rs1_addr_i,
   input  logic [PROC_REGFILE_LOG2_DEEP-1:0] rs2_addr_i,
   input  logic [PROC_REGFILE_LOG2_DEEP-1:0] rd_addr_i,
   input  logic                              rd_we_i,
   input  logic                              is_load_i,
   input  logic                              use_imm_i,
   input  logic [IMM_WIDTH-1:0]              imm_i,
   output logic [PROC_REGFILE_LOG2_DEEP-1:0] rf_read_addr1_o,
   output logic [PROC_REGFILE_LOG2_DEEP-1:0] rf_read_addr2_o,
   input  logic [PROC_DATA_WIDTH-1:0]        rf_read_data1_i,
   input  logic [PROC_DATA_WIDTH-1:0]        rf_read_data2_i,
   input  logic [PROC_REGFILE_LOG2_DEEP-1:0] ex_rd_addr_i,
   input  logic                              ex_rd_we_i,
   input  logic                              ex_is_load_i,
   input  logic [PROC_DATA_WIDTH-1:0]        ex_rd_data_i,
   input  logic [PROC_REGFILE_LOG2_DEEP-1:0] mem_rd_addr_i,
   input  logic                              mem_rd_we_i,
   input  logic [PROC_DATA_WIDTH-1:0]        mem_rd_data_i,
   output logic                              out_valid_o,
   input  logic                              out_ready_i,
   output logic [OP_WIDTH-1:0]               out_op_o,
   output logic [PROC_DATA_WIDTH-1:0]        out_a_o,
   output logic [PROC_DATA_WIDTH-1:0]        out_b_o,
   output logic [PROC_DATA_WIDTH-1:0]        out_store_data_o,
   output logic [PROC_REGFILE_LOG2_DEEP-1:0] out_rd_addr_o,
   output logic                              out_rd_we_o,
   output logic                              out_is_load_o,
   output logic [15:0]                       stall_count_o
);

   localparam int DW = PROC_DATA_WIDTH;
   localparam int AW = PROC_REGFILE_LOG2_DEEP;

   function automatic logic src_match(input logic [AW-1:0] r,
                                      input logic [AW-1:0] a,
                                      input logic          w);
      return (r != '0) && w && (r == a);
   endfunction

   // Priority: hard zero, then EX ALU result, then MEM result, then register file.
   function automatic logic [DW-1:0] fwd(input logic [AW-1:0] r,
                                         input logic [DW-1:0] rf_data,
                                         input logic [AW-1:0] ex_addr,
                                         input logic          ex_we,
                                         input logic          ex_ld,
                                         input logic [DW-1:0] ex_data,
                                         input logic [AW-1:0] mem_addr,
                                         input logic          mem_we,
                                         input logic [DW-1:0] mem_data);
      logic [DW-1:0] res;
      if (r == '0)
         res = '0;
      else if (src_match(r, ex_addr, ex_we) && !ex_ld)
         res = ex_data;
      else if (src_match(r, mem_addr, mem_we))
         res = mem_data;
      else
         res = rf_data;
      return res;
   endfunction

   logic                out_valid_q, out_valid_d;
   logic [OP_WIDTH-1:0] out_op_q, out_op_d;
   logic [DW-1:0]       out_a_q, out_a_d;
   logic [DW-1:0]       out_b_q, out_b_d;
   logic [DW-1:0]       out_sd_q, out_sd_d;
   logic [AW-1:0]       out_rd_addr_q, out_rd_addr_d;
   logic                out_rd_we_q, out_rd_we_d;
   logic                out_is_load_q, out_is_load_d;
   logic [15:0]         stall_count_q, stall_count_d;

   logic          adv;
   logic          idex_load_we;
   logic          ex_load_we;
   logic          hz;
   logic [DW-1:0] fwd_a;
   logic [DW-1:0] fwd_b;
   logic [DW-1:0] imm_ext;

   assign rf_read_addr1_o = rs1_addr_i;
   assign rf_read_addr2_o = rs2_addr_i;

   always_comb begin
      adv          = out_ready_i | ~out_valid_q;
      idex_load_we = out_rd_we_q & out_valid_q & out_is_load_q;
      ex_load_we   = ex_rd_we_i & ex_is_load_i;
      hz = in_valid_i &
           (src_match(rs1_addr_i, out_rd_addr_q, idex_load_we) |
            src_match(rs2_addr_i, out_rd_addr_q, idex_load_we) |
            src_match(rs1_addr_i, ex_rd_addr_i, ex_load_we)    |
            src_match(rs2_addr_i, ex_rd_addr_i, ex_load_we));
      fwd_a = fwd(rs1_addr_i, rf_read_data1_i, ex_rd_addr_i, ex_rd_we_i, ex_is_load_i,
                  ex_rd_data_i, mem_rd_addr_i, mem_rd_we_i, mem_rd_data_i);
      fwd_b = fwd(rs2_addr_i, rf_read_data2_i, ex_rd_addr_i, ex_rd_we_i, ex_is_load_i,
                  ex_rd_data_i, mem_rd_addr_i, mem_rd_we_i, mem_rd_data_i);
      imm_ext    = {{(DW-IMM_WIDTH){imm_i[IMM_WIDTH-1]}}, imm_i};
      in_ready_o = ~rst_i & (flush_i | (adv & ~hz));
   end

   always_comb begin
      out_valid_d   = out_valid_q;
      out_op_d      = out_op_q;
      out_a_d       = out_a_q;
      out_b_d       = out_b_q;
      out_sd_d      = out_sd_q;
      out_rd_addr_d = out_rd_addr_q;
      out_rd_we_d   = out_rd_we_q;
      out_is_load_d = out_is_load_q;
      stall_count_d = stall_count_q;
      if (flush_i) begin
         out_valid_d = 1'b0;
         out_rd_we_d = 1'b0;
      end else if (adv && in_valid_i && !hz) begin
         out_valid_d   = 1'b1;
         out_op_d      = op_i;
         out_a_d       = fwd_a;
         out_b_d       = use_imm_i ? imm_ext : fwd_b;
         out_sd_d      = fwd_b;
         out_rd_addr_d = rd_addr_i;
         out_rd_we_d   = rd_we_i;
         out_is_load_d = is_load_i;
      end else if (adv) begin
         out_valid_d   = 1'b0;
         out_rd_we_d   = 1'b0;
         out_is_load_d = 1'b0;
         if (hz && stall_count_q != 16'hFFFF)
            stall_count_d = stall_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_q   <= 1'b0;
         out_op_q      <= '0;
         out_a_q       <= '0;
         out_b_q       <= '0;
         out_sd_q      <= '0;
         out_rd_addr_q <= '0;
         out_rd_we_q   <= 1'b0;
         out_is_load_q <= 1'b0;
         stall_count_q <= '0;
      end else begin
         out_valid_q   <= out_valid_d;
         out_op_q      <= out_op_d;
         out_a_q       <= out_a_d;
         out_b_q       <= out_b_d;
         out_sd_q      <= out_sd_d;
         out_rd_addr_q <= out_rd_addr_d;
         out_rd_we_q   <= out_rd_we_d;
         out_is_load_q <= out_is_load_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign out_valid_o      = out_valid_q;
   assign out_op_o         = out_op_q;
   assign out_a_o          = out_a_q;
   assign out_b_o          = out_b_q;
   assign out_store_data_o = out_sd_q;
   assign out_rd_addr_o    = out_rd_addr_q;
   assign out_rd_we_o      = out_rd_we_q;
   assign out_is_load_o    = out_is_load_q;
   assign stall_count_o    = stall_count_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios plus random traffic, all
// compared against a queue-based model of the ID/EX register.
module tb_operand_fetch_stage;
   localparam int DW = 16;
   localparam int AW = 5;
   localparam int IW = 8;
   localparam int OW = 4;

   typedef struct packed {
      logic [OW-1:0] op;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] sd;
      logic [AW-1:0] rd;
      logic          we;
      logic          ld;
   } rec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_i, flush_i, in_valid_i, in_ready_o;
   logic [OW-1:0] op_i;
   logic [AW-1:0] rs1_addr_i, rs2_addr_i, rd_addr_i;
   logic          rd_we_i, is_load_i, use_imm_i;
   logic [IW-1:0] imm_i;
   logic [AW-1:0] rf_read_addr1_o, rf_read_addr2_o;
   logic [DW-1:0] rf_read_data1_i, rf_read_data2_i;
   logic [AW-1:0] ex_rd_addr_i, mem_rd_addr_i;
   logic          ex_rd_we_i, ex_is_load_i, mem_rd_we_i;
   logic [DW-1:0] ex_rd_data_i, mem_rd_data_i;
   logic          out_valid_o, out_ready_i;
   logic [OW-1:0] out_op_o;
   logic [DW-1:0] out_a_o, out_b_o, out_store_data_o;
   logic [AW-1:0] out_rd_addr_o;
   logic          out_rd_we_o, out_is_load_o;
   logic [15:0]   stall_count_o;

   operand_fetch_stage #(
      .PROC_DATA_WIDTH(DW), .PROC_REGFILE_LOG2_DEEP(AW), .IMM_WIDTH(IW), .OP_WIDTH(OW)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .op_i(op_i),
      .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
      .rd_we_i(rd_we_i), .is_load_i(is_load_i), .use_imm_i(use_imm_i), .imm_i(imm_i),
      .rf_read_addr1_o(rf_read_addr1_o), .rf_read_addr2_o(rf_read_addr2_o),
      .rf_read_data1_i(rf_read_data1_i), .rf_read_data2_i(rf_read_data2_i),
      .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_we_i(ex_rd_we_i), .ex_is_load_i(ex_is_load_i),
      .ex_rd_data_i(ex_rd_data_i),
      .mem_rd_addr_i(mem_rd_addr_i), .mem_rd_we_i(mem_rd_we_i), .mem_rd_data_i(mem_rd_data_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_op_o(out_op_o),
      .out_a_o(out_a_o), .out_b_o(out_b_o), .out_store_data_o(out_store_data_o),
      .out_rd_addr_o(out_rd_addr_o), .out_rd_we_o(out_rd_we_o),
      .out_is_load_o(out_is_load_o), .stall_count_o(stall_count_o)
   );

   int   n_checks = 0;
   int   n_errors = 0;
   int   m_stall  = 0;
   rec_t exp_q[$];   // contents of the ID/EX register, empty when it holds nothing

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic hit(input logic [AW-1:0] r, input logic [AW-1:0] a, input logic w);
      return (r != 0) && w && (r == a);
   endfunction

   function automatic logic [DW-1:0] ref_fwd(input logic [AW-1:0] r, input logic [DW-1:0] rf);
      if (r == 0) return '0;
      if (hit(r, ex_rd_addr_i, ex_rd_we_i) && !ex_is_load_i) return ex_rd_data_i;
      if (hit(r, mem_rd_addr_i, mem_rd_we_i)) return mem_rd_data_i;
      return rf;
   endfunction

   function automatic logic ref_hz();
      logic          load_held;
      logic [AW-1:0] srcs [2];
      if (!in_valid_i) return 1'b0;
      load_held = (exp_q.size() != 0) && exp_q[0].ld && exp_q[0].we;
      srcs[0] = rs1_addr_i;
      srcs[1] = rs2_addr_i;
      for (int k = 0; k < 2; k++) begin
         if (load_held && hit(srcs[k], exp_q[0].rd, 1'b1)) return 1'b1;
         if (hit(srcs[k], ex_rd_addr_i, ex_rd_we_i && ex_is_load_i)) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic rec_t ref_rec();
      rec_t                 r;
      logic signed [IW-1:0] simm;
      simm = imm_i;
      r.op = op_i;
      r.a  = ref_fwd(rs1_addr_i, rf_read_data1_i);
      r.sd = ref_fwd(rs2_addr_i, rf_read_data2_i);
      r.b  = use_imm_i ? DW'(simm) : r.sd;
      r.rd = rd_addr_i;
      r.we = rd_we_i;
      r.ld = is_load_i;
      return r;
   endfunction

   task automatic idle_inputs();
      flush_i = 0; in_valid_i = 0; op_i = 0; rs1_addr_i = 0; rs2_addr_i = 0;
      rd_addr_i = 0; rd_we_i = 0; is_load_i = 0; use_imm_i = 0; imm_i = 0;
      rf_read_data1_i = 0; rf_read_data2_i = 0;
      ex_rd_addr_i = 0; ex_rd_we_i = 0; ex_is_load_i = 0; ex_rd_data_i = 0;
      mem_rd_addr_i = 0; mem_rd_we_i = 0; mem_rd_data_i = 0; out_ready_i = 1;
   endtask

   task automatic set_inst(input logic [OW-1:0] op, input logic [AW-1:0] rs1,
                           input logic [AW-1:0] rs2, input logic [AW-1:0] rd,
                           input logic we, input logic ld);
      in_valid_i = 1; op_i = op; rs1_addr_i = rs1; rs2_addr_i = rs2;
      rd_addr_i = rd; rd_we_i = we; is_load_i = ld;
   endtask

   // Called just after a falling edge with inputs applied; returns at the next falling edge.
   task automatic step();
      logic adv, hz, was_rst;
      #1;
      was_rst = rst_i;
      check("rf_addr1", 64'(rf_read_addr1_o), 64'(rs1_addr_i));
      check("rf_addr2", 64'(rf_read_addr2_o), 64'(rs2_addr_i));
      if (rst_i) begin
         check("in_ready_rst", 64'(in_ready_o), 64'd0);
         exp_q.delete();
         m_stall = 0;
      end else begin
         adv = out_ready_i || (exp_q.size() == 0);
         hz  = ref_hz();
         check("in_ready", 64'(in_ready_o), 64'(flush_i || (adv && !hz)));
         if (flush_i) begin
            exp_q.delete();
         end else if (adv) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (in_valid_i && !hz) exp_q.push_back(ref_rec());
            else if (hz && m_stall < 65535) m_stall++;
         end
      end
      @(posedge clk);
      #1;
      check("out_valid", 64'(out_valid_o), 64'(exp_q.size() != 0));
      check("stall_count", 64'(stall_count_o), 64'(m_stall));
      if (exp_q.size() != 0) begin
         check("out_op", 64'(out_op_o), 64'(exp_q[0].op));
         check("out_a", 64'(out_a_o), 64'(exp_q[0].a));
         check("out_b", 64'(out_b_o), 64'(exp_q[0].b));
         check("out_sd", 64'(out_store_data_o), 64'(exp_q[0].sd));
         check("out_rd", 64'(out_rd_addr_o), 64'(exp_q[0].rd));
         check("out_we", 64'(out_rd_we_o), 64'(exp_q[0].we));
         check("out_ld", 64'(out_is_load_o), 64'(exp_q[0].ld));
      end else begin
         check("out_we_idle", 64'(out_rd_we_o), 64'd0);
      end
      if (was_rst) begin
         check("rst_zero", 64'({out_op_o, out_a_o, out_b_o}), 64'd0);
         check("rst_zero2", 64'({out_store_data_o, out_rd_addr_o, out_is_load_o}), 64'd0);
      end
      @(negedge clk);
   endtask

   task automatic random_inputs();
      flush_i         = ($urandom_range(0, 15) == 0);
      in_valid_i      = ($urandom_range(0, 3) != 0);
      op_i            = OW'($urandom_range(0, 15));
      rs1_addr_i      = AW'($urandom_range(0, 7));
      rs2_addr_i      = AW'($urandom_range(0, 7));
      rd_addr_i       = AW'($urandom_range(0, 7));
      rd_we_i         = 1'($urandom_range(0, 1));
      is_load_i       = ($urandom_range(0, 3) == 0);
      use_imm_i       = 1'($urandom_range(0, 1));
      imm_i           = IW'($urandom_range(0, 255));
      rf_read_data1_i = DW'($urandom);
      rf_read_data2_i = DW'($urandom);
      ex_rd_addr_i    = AW'($urandom_range(0, 7));
      ex_rd_we_i      = 1'($urandom_range(0, 1));
      ex_is_load_i    = ($urandom_range(0, 3) == 0);
      ex_rd_data_i    = DW'($urandom);
      mem_rd_addr_i   = AW'($urandom_range(0, 7));
      mem_rd_we_i     = 1'($urandom_range(0, 1));
      mem_rd_data_i   = DW'($urandom);
      out_ready_i     = ($urandom_range(0, 3) != 0);
   endtask

   initial begin
      idle_inputs();
      rst_i = 1;
      set_inst(4'h1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
      @(negedge clk);
      step();
      step();
      rst_i = 0;
      step();
      check("first_valid", 64'(out_valid_o), 64'd1);

      // ALU result forwarded from EX
      idle_inputs();
      ex_rd_addr_i = 5'd3; ex_rd_we_i = 1; ex_rd_data_i = 16'h1234;
      rf_read_data1_i = 16'h0BAD; rf_read_data2_i = 16'h0BAD;
      set_inst(4'h2, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0);
      step();
      check("alu_fwd_a", 64'(out_a_o), 64'h1234);
      check("alu_fwd_b", 64'(out_b_o), 64'h0);

      // EX beats MEM, negative immediate sign-extended
      idle_inputs();
      ex_rd_addr_i = 5'd5; ex_rd_we_i = 1; ex_rd_data_i = 16'hAAAA;
      mem_rd_addr_i = 5'd5; mem_rd_we_i = 1; mem_rd_data_i = 16'h5555;
      use_imm_i = 1; imm_i = 8'hF0;
      set_inst(4'h3, 5'd5, 5'd6, 5'd6, 1'b1, 1'b0);
      step();
      check("prio_a", 64'(out_a_o), 64'hAAAA);
      check("imm_b", 64'(out_b_o), 64'hFFF0);

      // Load-use: load r7, then a store reading r7
      idle_inputs();
      set_inst(4'h4, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1);
      step();
      idle_inputs();
      set_inst(4'h5, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0);
      step();
      check("lu_bubble", 64'(out_valid_o), 64'd0);
      ex_rd_addr_i = 5'd7; ex_rd_we_i = 1; ex_is_load_i = 1;
      step();
      ex_rd_we_i = 0; ex_is_load_i = 0;
      mem_rd_addr_i = 5'd7; mem_rd_we_i = 1; mem_rd_data_i = 16'hBEEF;
      rf_read_data2_i = 16'h1111;
      step();
      check("lu_store", 64'(out_store_data_o), 64'hBEEF);

      // Load to r0 never creates a hazard
      idle_inputs();
      set_inst(4'h6, 5'd1, 5'd1, 5'd0, 1'b1, 1'b1);
      step();
      set_inst(4'h7, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0);
      step();
      check("r0_no_hz", 64'(out_op_o), 64'h7);

      // Backpressure for three cycles, then resume
      idle_inputs();
      set_inst(4'h8, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
      rf_read_data1_i = 16'h0101;
      step();
      set_inst(4'h9, 5'd2, 5'd3, 5'd4, 1'b1, 1'b0);
      out_ready_i = 0;
      for (int i = 0; i < 3; i++) step();
      check("bp_hold", 64'(out_op_o), 64'h8);
      out_ready_i = 1;
      step();
      check("bp_resume", 64'(out_op_o), 64'h9);

      // Flush drops the presented instruction, and a hazard under flush is not counted
      set_inst(4'hD, 5'd1, 5'd1, 5'd7, 1'b1, 1'b1);
      flush_i = 1;
      step();
      check("flush_kill", 64'(out_valid_o), 64'd0);
      flush_i = 0;
      set_inst(4'hA, 5'd1, 5'd1, 5'd7, 1'b1, 1'b1);
      step();
      set_inst(4'hB, 5'd7, 5'd0, 5'd1, 1'b1, 1'b0);
      flush_i = 1;
      step();
      flush_i = 0;
      in_valid_i = 0;
      step();

      for (int i = 0; i < 3000; i++) begin
         random_inputs();
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
